// File: rtl/mmio_uart_tx_if.sv
// Processor MEM-stage load/store port as seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output MemRead, output Address, output WriteData,
                  input  ReadData);
  modport slave  (input  MemWrite, input  MemRead, input  Address, input  WriteData,
                  output ReadData);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store bytes to DATA_ADDR, they queue in a small
// FIFO and are shifted out LSB first; STATUS_ADDR reports overflow/count/busy/full.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = 32'hFFFF0000,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF0004
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [15:0]   baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          overflow;

  logic          dataSel, statusSel, full, push, pop;
  logic [4:0]    countWide;
  logic [2:0]    countSat;
  logic          unusedBits;

  assign dataSel    = (bus.Address == DATA_ADDR);
  assign statusSel  = (bus.Address == STATUS_ADDR);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = bus.MemWrite && dataSel && !full;
  assign pop        = (state == IDLE) && (count != '0);
  assign countWide  = 5'(count);
  assign countSat   = (countWide > 5'd7) ? 3'd7 : countWide[2:0];
  assign unusedBits = ^bus.WriteData[31:8];

  always_comb begin
    busy = (state != IDLE) || (count != '0);
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead && statusSel)
      bus.ReadData = {26'b0, overflow, countSat, busy, full};
  end

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.MemWrite && dataSel && full)
        overflow <= 1'b1;
      else if (bus.MemWrite && statusSel)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      rdPtr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shiftReg <= mem[rdPtr];
            rdPtr    <= rdPtr + 1'b1;
            baudCnt  <= BAUD_RELOAD;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_RELOAD;
            bitIdx  <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        DATA: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_RELOAD;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              tx     <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        STOP: begin
          if (baudCnt == '0)
            state <= IDLE;
          else
            baudCnt <= baudCnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-003 Parameter DATA_ADDR, default 32'hFFFF0000: byte address of the transmit-data register.
REQ-004 Parameter STATUS_ADDR, default 32'hFFFF0004: byte address of the status register.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port MemWrite, input, 1: store strobe from the processor MEM stage.
REQ-008 Port MemRead, input, 1: load strobe from the processor MEM stage.
REQ-009 Port Address, input, 32: byte address from the processor MEM stage (ALU result).
REQ-010 Port WriteData, input, 32: store data; only bits [7:0] are used.
REQ-011 Port ReadData, output, 32: load data for the WB-stage mux.
REQ-012 Port tx, output, 1: serial line, 8N1, LSB first, idle high.
REQ-013 Port busy, output, 1: high while the FSM is outside IDLE or the FIFO is non-empty.

Function
REQ-014 A push SHALL occur on a rising edge when MemWrite=1, Address==DATA_ADDR and count<FIFO_DEPTH; it stores WriteData[7:0].
REQ-015 A write to DATA_ADDR while count==FIFO_DEPTH SHALL be dropped and SHALL set the sticky overflow bit. Fullness is sampled before the edge, so a same-cycle pop does not make room.
REQ-016 A write to STATUS_ADDR (any data) SHALL clear overflow. A simultaneous overflow event cannot occur because the addresses differ.
REQ-017 ReadData SHALL be combinational:
- MemRead=1 and Address==STATUS_ADDR: {26'b0, overflow, count[2:0] (saturated to 7), busy, full}.
- All other cases: 32'b0.
REQ-018 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-019 IDLE: if count>0 at an edge, pop the head byte into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START. tx is low from that edge.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-021 DATA: tx = shift[bit index] for CLKS_PER_BIT cycles per bit; indices 0..7 in order; after bit 7, go to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 Each frame SHALL be exactly 10*CLKS_PER_BIT cycles. The next frame is popped on the edge after the return to IDLE, giving one idle-high cycle between back-to-back frames.
REQ-024 A push into an empty FIFO with the FSM in IDLE SHALL NOT bypass the FIFO. tx falls one cycle after the push edge.
REQ-025 A simultaneous push and pop with count<FIFO_DEPTH SHALL leave count unchanged and preserve order.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH, and track count separately (0..FIFO_DEPTH).
REQ-027 The baud counter SHALL be 16 bits, down-counting to 0, and reloaded on every bit boundary.
REQ-028 MemRead has no side effects, and accesses to other addresses SHALL be ignored.

Reset
REQ-029 reset=0 SHALL immediately, asynchronously:
- set FSM to IDLE, tx=1, busy=0, count=0, pointers=0, overflow=0, baud counter=0;
- leave FIFO storage contents unspecified.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard queued bytes, with tx high in the same cycle. The first edge after release SHALL see IDLE with an empty FIFO.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte: store 8'hA5 to DATA_ADDR at edge 0.
- tx goes low after edge 1 for 4 cycles.
- Data bits follow: 1,0,1,0,0,1,0,1.
- Stop bit high; tx is back in IDLE after edge 41; busy falls then.
REQ-032 Overflow: 6 consecutive stores 8'h01..8'h06 starting at edge 0.
- 8'h01 pops at edge 1; 02..05 fill the FIFO; 06 is dropped.
- Status read returns full=1, overflow=1.
- Serial output is 01,02,03,04,05 only.
REQ-033 Overflow clear: after REQ-032, store any value to STATUS_ADDR, then read status: bit 5=0, with bits 0..4 reflecting live state.
REQ-034 Back-to-back: store 8'h00 then 8'hFF.
- Frames are 40 cycles each, separated by exactly 1 high cycle.
- Frame 2 start bit begins 41 cycles after frame 1 start bit.
REQ-035 Reset mid-frame: assert reset=0 during DATA bit 3 with 2 bytes queued.
- tx=1 and busy=0 in the same cycle.
- After release, status reads 32'h0 and tx stays high with no further frames.
REQ-036 Decode isolation: store to 32'h10010000 and read from 32'hFFFF0008.
- No push occurs; ReadData=0; count is unchanged.
